tawas_rcn_slave_buf: RTL and testbench

//  RCN ring responder: decodes request packets addressed to this node and queues them. It runs them one at a time on a

---
 rtl/tawas_rcn_pkg.sv | 32 +++
 rtl/tawas_rcn_slave_fifo.sv | 57 +++++
 rtl/tawas_rcn_slave_buf.sv | 160 ++++++++++++++++
 tb/tb_tawas_rcn_slave_buf.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tawas_rcn_pkg.sv
// Shared RCN ring definitions: packet field positions, packet width,
// the data word returned on a local-port timeout, and the responder FSM states.
package tawas_rcn_pkg;

  localparam int RCN_W       = 69;
  localparam int RCN_VALID   = 68;
  localparam int RCN_REQ     = 67;
  localparam int RCN_WR      = 66;
  localparam int RCN_ID_HI   = 65;
  localparam int RCN_ID_LO   = 60;
  localparam int RCN_MASK_HI = 59;
  localparam int RCN_MASK_LO = 56;
  localparam int RCN_ADDR_HI = 55;
  localparam int RCN_ADDR_LO = 34;
  localparam int RCN_SEQ_HI  = 33;
  localparam int RCN_SEQ_LO  = 32;
  localparam int RCN_DATA_HI = 31;
  localparam int RCN_DATA_LO = 0;

  localparam logic [31:0] RCN_TIMEOUT_DATA = 32'hDEAD_DEAD;

  typedef enum logic {
    SLV_IDLE   = 1'b0,
    SLV_ACCESS = 1'b1
  } slv_state_e;

  // Word-aligned byte address carried by a packet.
  function automatic logic [23:0] rcn_byte_addr(input logic [RCN_W-1:0] pkt);
    return {pkt[RCN_ADDR_HI:RCN_ADDR_LO], 2'b00};
  endfunction

endpackage

// File: rtl/tawas_rcn_slave_fifo.sv
// Request queue for the RCN responder: synchronous FIFO of ring packets.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
// The head entry is visible combinationally so it can stay queued while served.
module tawas_rcn_slave_fifo
  import tawas_rcn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [RCN_W-1:0]     din,
  input  logic                 pop,
  output logic [RCN_W-1:0]     head,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);

  logic [RCN_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; a push into a full queue is only taken when a pop frees a slot.
  always_comb begin
    do_push  = push & (~full | pop);
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/tawas_rcn_slave_buf.sv
// RCN ring responder with a request queue. Decodes requests for this node,
// queues them, runs them one at a time on the local port and inserts the
// responses back into free ring slots.
// Optional feature macro: TAWAS_RCN_SLAVE_TIMEOUT_EN (local-port wait limit).
module tawas_rcn_slave_buf
  import tawas_rcn_pkg::*;
#(
  parameter logic [23:0] ADDR_MASK      = 24'hFF0000,
  parameter logic [23:0] ADDR_BASE      = 24'h010000,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [68:0] rcn_in,
  output logic [68:0] rcn_out,
  output logic        cs,
  output logic        wr,
  output logic [23:0] addr,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  input  logic        ack,
  input  logic [31:0] rdata
);

  logic             hit, push, pop;
  logic             fifo_full, fifo_empty;
  logic [RCN_W-1:0] head;
  logic [RCN_W-1:0] rcn_out_q, rcn_out_d;
  logic [RCN_W-1:0] resp_q, resp_d;
  logic             resp_take, done;
  logic [31:0]      resp_data;
  slv_state_e       state_q, state_d;
  logic             wr_q, wr_d;
  logic [23:0]      addr_q, addr_d;
  logic [3:0]       mask_q, mask_d;
  logic [31:0]      wdata_q, wdata_d;

`ifdef TAWAS_RCN_SLAVE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign hit  = rcn_in[RCN_VALID] & rcn_in[RCN_REQ] &
                ((rcn_byte_addr(rcn_in) & ADDR_MASK) == ADDR_BASE);
  assign push = hit & ~fifo_full;

  assign rcn_out = rcn_out_q;
  assign cs      = (state_q == SLV_ACCESS);
  assign wr      = wr_q;
  assign addr    = addr_q;
  assign mask    = mask_q;
  assign wdata   = wdata_q;

  // The head stays queued while it is being served, so the in-flight request
  // occupies a queue entry and its fields remain available for the response.
  tawas_rcn_slave_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rcn_in),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Ring mux: forward anything not consumed, else fill the free slot with a response.
  always_comb begin
    rcn_out_d = '0;
    resp_take = 1'b0;
    if (rcn_in[RCN_VALID] && !push) begin
      rcn_out_d = rcn_in;
    end else if (resp_q[RCN_VALID]) begin
      rcn_out_d = resp_q;
      resp_take = 1'b1;
    end
  end

  // Local-port FSM: start an access from the queue head, finish on ack (or timeout).
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    done      = 1'b0;
    pop       = 1'b0;
    resp_data = rdata;
    resp_d    = resp_q;
`ifdef TAWAS_RCN_SLAVE_TIMEOUT_EN
    tmo_d     = '0;
`endif
    if (resp_take) begin
      resp_d = '0;
    end
    case (state_q)
      SLV_IDLE: begin
        // Queued entries are always valid requests; the check keeps a stale slot from issuing.
        if (!fifo_empty && !resp_q[RCN_VALID] && head[RCN_VALID] && head[RCN_REQ]) begin
          state_d = SLV_ACCESS;
          wr_d    = head[RCN_WR];
          addr_d  = rcn_byte_addr(head);
          mask_d  = head[RCN_MASK_HI:RCN_MASK_LO];
          wdata_d = head[RCN_DATA_HI:RCN_DATA_LO];
        end
      end
      SLV_ACCESS: begin
        if (ack) begin
          done      = 1'b1;
          resp_data = head[RCN_WR] ? head[RCN_DATA_HI:RCN_DATA_LO] : rdata;
        end
`ifdef TAWAS_RCN_SLAVE_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          done      = 1'b1;
          resp_data = RCN_TIMEOUT_DATA;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = SLV_IDLE;
    endcase
    if (done) begin
      state_d = SLV_IDLE;
      pop     = 1'b1;
      resp_d  = {1'b1, 1'b0, head[RCN_WR:RCN_SEQ_LO], resp_data};
    end
  end

  // State, local-port and ring registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SLV_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      mask_q    <= '0;
      wdata_q   <= '0;
      resp_q    <= '0;
      rcn_out_q <= '0;
`ifdef TAWAS_RCN_SLAVE_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      wdata_q   <= wdata_d;
      resp_q    <= resp_d;
      rcn_out_q <= rcn_out_d;
`ifdef TAWAS_RCN_SLAVE_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_tawas_rcn_slave_buf.sv
// Directed bench for tawas_rcn_slave_buf with a ring-output scoreboard.
// Honors TAWAS_RCN_SLAVE_TIMEOUT_EN for the timeout scenario.
module tb_tawas_rcn_slave_buf;
  import tawas_rcn_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [68:0] rcn_in, rcn_out;
  logic        cs, wr, ack;
  logic [23:0] addr;
  logic [3:0]  mask;
  logic [31:0] wdata, rdata;

  int          total = 0;
  int          bad   = 0;
  logic [68:0] exp_q[$];
  logic [68:0] e_pkt;

  tawas_rcn_slave_buf dut (
    .clk     (clk),
    .rst     (rst),
    .rcn_in  (rcn_in),
    .rcn_out (rcn_out),
    .cs      (cs),
    .wr      (wr),
    .addr    (addr),
    .mask    (mask),
    .wdata   (wdata),
    .ack     (ack),
    .rdata   (rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [68:0] mk(input logic req, input logic w, input logic [5:0] id,
                                     input logic [3:0] m, input logic [23:0] a,
                                     input logic [1:0] seq, input logic [31:0] d);
    return {1'b1, req, w, id, m, a[23:2], seq, d};
  endfunction

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [68:0] p);
    rcn_in = p;
    tick();
    rcn_in = '0;
  endtask

  task automatic wait_cs(input string tag, input int budget);
    int n = 0;
    while (cs !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    total++;
    assert (cs === 1'b1) else begin
      bad++;
      $error("FAIL %s observed cs=%b expected cs=1 within %0d cycles", tag, cs, budget);
    end
  endtask

  task automatic do_ack(input logic [31:0] d);
    rdata = d;
    ack   = 1'b1;
    tick();
    ack   = 1'b0;
    rdata = '0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL %s observed pending=%0d expected pending=0", tag, exp_q.size());
    end
  endtask

  // Scoreboard: every valid ring output must match the next expected packet.
  always @(negedge clk) begin
    if (rst === 1'b0 && rcn_out[68] === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("ring_unexpected", rcn_out, 69'd0);
      end else begin
        e_pkt = exp_q.pop_front();
        $display("ring out: %h (req=%b id=%0d seq=%0d data=%h)", rcn_out, rcn_out[67],
                 rcn_out[65:60], rcn_out[33:32], rcn_out[31:0]);
        chk("ring_pkt", rcn_out, e_pkt);
      end
    end
  end

  initial begin
    logic [68:0] p;
    logic [68:0] h[6];
    logic [23:0] ha[6];
    int          n;

    rst = 1'b1; rcn_in = '0; ack = 1'b0; rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_rcn_out", rcn_out, 69'd0);
    chk("rst_cs", 69'(cs), 69'd0);
    chk("rst_wr", 69'(wr), 69'd0);
    chk("rst_addr", 69'(addr), 69'd0);
    chk("rst_mask", 69'(mask), 69'd0);
    chk("rst_wdata", 69'(wdata), 69'd0);

    // Read with exact latency, ack after three cycles.
    p = mk(1'b1, 1'b0, 6'd5, 4'hF, 24'h010004, 2'd2, 32'h0);
    send(p);
    $display("req read 010004 id=5 seq=2");
    chk("rd_cs_n1", 69'(cs), 69'd0);
    tick();
    chk("rd_cs_n2", 69'(cs), 69'd1);
    chk("rd_addr", 69'(addr), 69'h010004);
    chk("rd_wr", 69'(wr), 69'd0);
    chk("rd_mask", 69'(mask), 69'hF);
    repeat (3) tick();
    chk("rd_cs_hold", 69'(cs), 69'd1);
    exp_q.push_back(mk(1'b0, 1'b0, 6'd5, 4'hF, 24'h010004, 2'd2, 32'h12345678));
    do_ack(32'h12345678);
    chk("rd_cs_drop", 69'(cs), 69'd0);
    drain("rd_drain", 10);

    // Write: response echoes write data, rdata ignored.
    p = mk(1'b1, 1'b1, 6'd9, 4'h3, 24'h010008, 2'd1, 32'hA5A5A5A5);
    send(p);
    $display("req write 010008 data=a5a5a5a5");
    wait_cs("wr_cs", 10);
    chk("wr_wr", 69'(wr), 69'd1);
    chk("wr_addr", 69'(addr), 69'h010008);
    chk("wr_mask", 69'(mask), 69'h3);
    chk("wr_wdata", 69'(wdata), 69'hA5A5A5A5);
    exp_q.push_back(mk(1'b0, 1'b1, 6'd9, 4'h3, 24'h010008, 2'd1, 32'hA5A5A5A5));
    do_ack(32'h0BADF00D);
    drain("wr_drain", 10);

    // Miss: forwarded unchanged, no local access.
    p = mk(1'b1, 1'b0, 6'd7, 4'hF, 24'h020000, 2'd0, 32'h11);
    exp_q.push_back(p);
    send(p);
    $display("req miss 020000");
    repeat (4) begin
      chk("miss_cs", 69'(cs), 69'd0);
      tick();
    end
    drain("miss_drain", 5);

    // Six back-to-back hits with ack low: four queued, two forwarded.
    for (int i = 0; i < 6; i++) begin
      ha[i] = (i == 3) ? 24'h01FFFC : 24'h010100 + 24'(i * 4);
      h[i]  = mk(1'b1, 1'b0, 6'(i), 4'hF, ha[i], 2'(i), 32'h0);
    end
    exp_q.push_back(h[4]);
    exp_q.push_back(h[5]);
    for (int i = 0; i < 6; i++) begin
      rcn_in = h[i];
      tick();
    end
    rcn_in = '0;
    $display("burst of six hits issued");
    for (int i = 0; i < 4; i++) begin
      wait_cs("burst_cs", 20);
      chk("burst_addr", 69'(addr), 69'(ha[i]));
      exp_q.push_back(mk(1'b0, 1'b0, 6'(i), 4'hF, ha[i], 2'(i), 32'hC0DE0000 + 32'(i)));
      do_ack(32'hC0DE0000 + 32'(i));
    end
    drain("burst_drain", 20);

    // Pending response waits behind continuous non-hit traffic.
    p = mk(1'b1, 1'b0, 6'd3, 4'hF, 24'h010010, 2'd3, 32'h0);
    send(p);
    wait_cs("busy_cs", 10);
    for (int k = 0; k < 6; k++) begin
      p = (k % 2 == 0) ? mk(1'b1, 1'b0, 6'(k), 4'hF, 24'h030000 + 24'(k * 4), 2'd0, 32'(k))
                       : mk(1'b0, 1'b0, 6'(k), 4'hF, 24'h010020, 2'd1, 32'(k));
      exp_q.push_back(p);
      rcn_in = p;
      ack    = (k == 1);
      rdata  = (k == 1) ? 32'h5555AAAA : 32'h0;
      tick();
    end
    rcn_in = '0; ack = 1'b0; rdata = '0;
    exp_q.push_back(mk(1'b0, 1'b0, 6'd3, 4'hF, 24'h010010, 2'd3, 32'h5555AAAA));
    drain("busy_drain", 10);

    // Local port never acks.
    p = mk(1'b1, 1'b0, 6'd1, 4'hF, 24'h010040, 2'd0, 32'h0);
    send(p);
    wait_cs("tmo_cs", 10);
`ifdef TAWAS_RCN_SLAVE_TIMEOUT_EN
    exp_q.push_back(mk(1'b0, 1'b0, 6'd1, 4'hF, 24'h010040, 2'd0, 32'hDEADDEAD));
    n = 1;
    while (cs === 1'b1 && n < 400) begin
      tick();
      if (cs === 1'b1) n++;
    end
    chk("tmo_len", 69'(n), 69'd255);
    drain("tmo_drain", 10);
    do_ack(32'h1);
    chk("tmo_stray_cs", 69'(cs), 69'd0);
    repeat (3) tick();
    chk("tmo_stray_idle", 69'(cs), 69'd0);
`else
    repeat (300) tick();
    chk("notmo_hold", 69'(cs), 69'd1);
    exp_q.push_back(mk(1'b0, 1'b0, 6'd1, 4'hF, 24'h010040, 2'd0, 32'h77));
    do_ack(32'h77);
    drain("notmo_drain", 10);
`endif

    // Reset mid-access drops cs and loses the request.
    p = mk(1'b1, 1'b0, 6'd2, 4'hF, 24'h010050, 2'd1, 32'h0);
    send(p);
    wait_cs("mrst_cs", 10);
    rst = 1'b1;
    tick();
    chk("mrst_cs_drop", 69'(cs), 69'd0);
    chk("mrst_rcn_out", rcn_out, 69'd0);
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("mrst_idle", 69'(cs), 69'd0);
    end
    chk("mrst_no_out", rcn_out, 69'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
